bht_predictor: RTL
==================

# bht_predictor

Parametrised bimodal/gshare branch predictor: a table of 2^IDX_W saturating CTR_W-bit counters with a registered lookup port, a resolved-branch update port, an optional global history register and a misprediction counter. It sits between fetch (lookup) and execute/branch resolution (update). After reset it clears the table itself with a one-entry-per-cycle sweep.

## Interface
- IDX_W, 10, table index width; depth = 2^IDX_W entries
- CTR_W, 2, counter width (>= 2)
- GHR_W, 0, global history bits; 0 = bimodal, otherwise gshare (GHR_W <= IDX_W)
- CNT_W, 16, misprediction counter width
- CLK  input  1  clock, all state on rising edge
- RST_N  input  1  asynchronous active-low reset
- lk_valid  input  1  lookup request this cycle
- lk_pc  input  IDX_W  low PC bits for lookup
- upd_valid  input  1  resolved-branch update this cycle
- upd_idx  input  IDX_W  table index returned from lookup (pred_idx carried down the pipe)
- upd_taken  input  1  actual branch outcome
- upd_pred  input  1  prediction that was used (pred_taken carried down the pipe)
- ready  output  1  table initialised, requests accepted
- pred_valid  output  1  pred_* valid this cycle
- pred_taken  output  1  predicted direction (counter MSB)
- pred_ctr  output  CTR_W  full counter value read
- pred_idx  output  IDX_W  index used for the lookup
- ghr  output  max(GHR_W,1)  current global history (0 when GHR_W = 0)
- mispred_cnt  output  CNT_W  saturating count of mispredicted updates

## Operation
- States: INIT, RUN. RST_N low: state = INIT, sweep pointer = 0, ghr = 0, mispred_cnt = 0, ready = 0, pred_valid = 0, pred_taken = 0, pred_ctr = 0, pred_idx = 0.
- INIT: each cycle write INIT_VAL = 2^(CTR_W-1)-1 (weakly not-taken) to entry[ptr], ptr++. After writing entry 2^IDX_W-1, go to RUN and set ready = 1. lk_valid/upd_valid ignored in INIT (no pred_valid, no ghr/counter change).
- Index: idx = lk_pc XOR zero-extended ghr (GHR_W = 0: idx = lk_pc).
- Lookup (RUN, lk_valid): next edge registers pred_ctr = entry[idx], pred_taken = MSB, pred_idx = idx, pred_valid = 1; otherwise pred_valid = 0 and other pred_* hold.
- Update (RUN, upd_valid): entry[upd_idx] <= taken ? min(c+1, 2^CTR_W-1) : max(c-1, 0); ghr <= {ghr[GHR_W-2:0], upd_taken}; if upd_pred != upd_taken, mispred_cnt increments, saturating at 2^CTR_W... at 2^CNT_W-1.
- Same-cycle lookup and update, same index: lookup returns the pre-update value; the index uses the pre-update ghr. Lookup in the following cycle sees the updated value.
- Reset mid-sweep or mid-operation: immediately back to INIT with ptr = 0; full sweep repeats.

## Timing
- Lookup latency 1 cycle (request at edge N, pred_* valid after edge N+1); one lookup per cycle, fully pipelined.
- Update takes effect at the next edge; one update per cycle; back-to-back updates to the same entry accumulate (no lost updates).
- Init latency: ready rises exactly 2^IDX_W cycles after the first rising CLK with RST_N high.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- IDX_W=4, CTR_W=2: release reset -> ready rises after exactly 16 cycles; lookup of each pc 0..15 returns pred_ctr=01, pred_taken=0.
- Bimodal, pc=5: 3 taken updates -> counter 01->10->11->11 (saturates); next lookup pred_taken=1, pred_ctr=11; 4 not-taken updates -> 00, holds at 00.
- Same-cycle lookup and update of idx 7 (counter 01, taken) -> pred_ctr=01 that cycle; next-cycle lookup returns 10.
- GHR_W=2: updates taken, not-taken -> ghr=2'b10; lookup pc=0x3 -> pred_idx=0x1.
- CNT_W=2: 5 updates with upd_pred != upd_taken, 2 with equal -> mispred_cnt saturates at 3.
- Assert RST_N low mid-sweep at cycle 8 and mid-run with non-zero ghr/counters -> ready=0, ghr=0, mispred_cnt=0, full 16-cycle sweep repeats, all entries back to 01.

Source files
------------

// File: rtl/bht_predictor.sv
// ---------------------------------------------------------------------------
// bht_predictor
//
// Bimodal / gshare branch direction predictor. It keeps a table of 2^IDX_W
// saturating CTR_W-bit counters. Lookups are registered and take one cycle.
// Resolved-branch updates take effect at the next edge. There is an optional
// global history register (GHR_W > 0 selects gshare indexing) and a
// saturating misprediction counter. After reset the table clears itself with
// a one-entry-per-cycle sweep. ready stays low until that sweep completes.
//
// Parameters
//   IDX_W  table index width (depth = 2^IDX_W)
//   CTR_W  counter width (>= 2)
//   GHR_W  global history bits, 0 = bimodal (GHR_W <= IDX_W)
//   CNT_W  misprediction counter width
//
// Ports
//   CLK, RST_N          clock (rising edge) / asynchronous active-low reset
//   lk_valid, lk_pc     lookup request and low PC bits
//   upd_valid, upd_idx  resolved-branch update and the table index it targets
//   upd_taken           actual branch outcome
//   upd_pred            prediction that was used for that branch
//   ready               table initialised, requests accepted
//   pred_valid          pred_* carry a fresh lookup result this cycle
//   pred_taken          predicted direction (counter MSB)
//   pred_ctr            full counter value read
//   pred_idx            table index used for the lookup
//   ghr                 global history (constant 0 in bimodal mode)
//   mispred_cnt         saturating count of mispredicted updates
// ---------------------------------------------------------------------------
module bht_predictor #(
    parameter int IDX_W = 10,
    parameter int CTR_W = 2,
    parameter int GHR_W = 0,
    parameter int CNT_W = 16
) (
    input  logic                                 CLK,
    input  logic                                 RST_N,
    input  logic                                 lk_valid,
    input  logic [IDX_W-1:0]                     lk_pc,
    input  logic                                 upd_valid,
    input  logic [IDX_W-1:0]                     upd_idx,
    input  logic                                 upd_taken,
    input  logic                                 upd_pred,
    output logic                                 ready,
    output logic                                 pred_valid,
    output logic                                 pred_taken,
    output logic [CTR_W-1:0]                     pred_ctr,
    output logic [IDX_W-1:0]                     pred_idx,
    output logic [((GHR_W > 0) ? GHR_W : 1)-1:0] ghr,
    output logic [CNT_W-1:0]                     mispred_cnt
);

    localparam int GW    = (GHR_W > 0) ? GHR_W : 1;
    localparam int DEPTH = 1 << IDX_W;

    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]      ghr_q, ghr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pv_q;
    logic               pt_q;
    logic [CTR_W-1:0]   pc_q;
    logic [IDX_W-1:0]   pi_q;

    logic [CTR_W-1:0]   table_q [DEPTH];

    logic               tbl_we;
    logic [IDX_W-1:0]   tbl_wa;
    logic [CTR_W-1:0]   tbl_wd;
    logic               lk_fire;
    logic [IDX_W-1:0]   lk_idx;
    logic [CTR_W-1:0]   rd_ctr;
    logic [CTR_W-1:0]   upd_ctr;

    function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] c,
                                                  input logic             taken);
        if (taken) begin
            return (c == CTR_MAX) ? c : c + 1'b1;
        end
        return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    // In bimodal mode ghr_q is held at zero, so the XOR reduces to lk_pc.
    assign lk_idx  = lk_pc ^ IDX_W'(ghr_q);
    // Both reads see the table before this edge's write. A same-cycle lookup
    // therefore returns the pre-update counter.
    assign rd_ctr  = table_q[lk_idx];
    assign upd_ctr = table_q[upd_idx];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        cnt_d   = cnt_q;
        tbl_we  = 1'b0;
        tbl_wa  = ptr_q;
        tbl_wd  = INIT_VAL;
        lk_fire = 1'b0;

        case (state_q)
            INIT: begin
                tbl_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;   // wraps to 0, ready for the next sweep
                if (ptr_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                lk_fire = lk_valid;
                if (upd_valid) begin
                    tbl_we = 1'b1;
                    tbl_wa = upd_idx;
                    tbl_wd = ctr_next(upd_ctr, upd_taken);
                    if (GHR_W > 0) begin
                        ghr_d = GW'({ghr_q, upd_taken});
                    end
                    if (upd_pred != upd_taken) begin
                        cnt_d = cnt_sat_inc(cnt_q);
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
            cnt_q   <= '0;
            pv_q    <= 1'b0;
            pt_q    <= 1'b0;
            pc_q    <= '0;
            pi_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
            cnt_q   <= cnt_d;
            pv_q    <= lk_fire;
            if (lk_fire) begin
                pt_q <= rd_ctr[CTR_W-1];
                pc_q <= rd_ctr;
                pi_q <= lk_idx;
            end
        end
    end

    // Table storage has no reset. The post-reset sweep initialises it before
    // any lookup or update is accepted.
    always_ff @(posedge CLK) begin
        if (tbl_we) begin
            table_q[tbl_wa] <= tbl_wd;
        end
    end

    assign ready       = (state_q == RUN);
    assign pred_valid  = pv_q;
    assign pred_taken  = pt_q;
    assign pred_ctr    = pc_q;
    assign pred_idx    = pi_q;
    assign ghr         = ghr_q;
    assign mispred_cnt = cnt_q;

endmodule
